digit_display: RTL

DIGIT_DISPLAY -- requirements
Module: digit_display

---
 rtl/digit_display_pkg.sv | 68 ++++++
 rtl/digit_display_bin2bcd8.sv | 60 ++++++
 rtl/digit_display.sv | 110 +++++++++++
 3 files changed

// File: rtl/digit_display_pkg.sv
// Shared constants for the 8-digit score/time display: segment patterns,
// digit-word field positions, slot-to-field map and converter state encoding.
package digit_display_pkg;

  localparam int unsigned NUM_SLOTS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int unsigned THOUS_LSB  = 24;
  localparam int unsigned HUND_LSB   = 20;
  localparam int unsigned TENS_LSB   = 16;
  localparam int unsigned ONES_LSB   = 12;
  localparam int unsigned TENTHS_LSB = 8;
  localparam int unsigned POINTS_LSB = 0;

  typedef enum logic [2:0] {
    FLD_PTS_ONES,
    FLD_PTS_TENS,
    FLD_PTS_HUND,
    FLD_TENTHS,
    FLD_ONES,
    FLD_TENS,
    FLD_HUND,
    FLD_THOUS
  } field_e;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_LATCH
  } conv_state_e;

  function automatic field_e slot_field(input logic [2:0] slot);
    field_e f;
    unique case (slot)
      3'd0:    f = FLD_PTS_ONES;
      3'd1:    f = FLD_PTS_TENS;
      3'd2:    f = FLD_PTS_HUND;
      3'd3:    f = FLD_TENTHS;
      3'd4:    f = FLD_ONES;
      3'd5:    f = FLD_TENS;
      3'd6:    f = FLD_HUND;
      default: f = FLD_THOUS;
    endcase
    return f;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] s;
    unique case (bcd)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/digit_display_bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, 8 shifts,
// result presented on the 9th cycle with done high; start always restarts).
module bin2bcd8
  import digit_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q;
  logic [19:0] sr_q;
  logic [2:0]  cnt_q;
  logic        busy_q;

  function automatic logic [19:0] shift_add3(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int unsigned i = 0; i < 3; i++) begin
      if (t[8 + 4*i +: 4] >= 4'd5) t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= CONV_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      state_q <= CONV_SHIFT;
      sr_q    <= {12'd0, bin};
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        CONV_SHIFT: begin
          sr_q  <= shift_add3(sr_q);
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= CONV_LATCH;
        end
        CONV_LATCH: begin
          state_q <= CONV_IDLE;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = (state_q == CONV_LATCH);
  assign bcd  = sr_q[19:8];

endmodule

// File: rtl/digit_display.sv
// Multiplexed 8-digit seven-segment driver: time digits plus binary points
// converted to BCD, with frame-synchronous snapshot and leading-zero blanking.
module digit_display
  import digit_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 65000,
  parameter int          BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [27:0] digit,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [27:8]   shadow_q;
  logic [11:0]   pts_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic        tick, wrap, snap;
  logic        conv_done;
  logic [11:0] conv_bcd;

  assign tick = (presc_q == PRESC_LAST);
  assign wrap = tick && (idx_q == 3'(NUM_SLOTS - 1));
  assign snap = wrap && !freeze;

  bin2bcd8 u_conv (
    .clk   (clk),
    .reset (reset),
    .start (snap),
    .bin   (digit[POINTS_LSB +: 8]),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  field_e     fld;
  logic [3:0] nib;
  logic       blank;
  logic [3:0] th, hu, te, on, tt, ph, pt, po;

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 3'd1 : idx_q;

    th = shadow_q[THOUS_LSB  +: 4];
    hu = shadow_q[HUND_LSB   +: 4];
    te = shadow_q[TENS_LSB   +: 4];
    on = shadow_q[ONES_LSB   +: 4];
    tt = shadow_q[TENTHS_LSB +: 4];
    po = pts_q[3:0];
    pt = pts_q[7:4];
    ph = pts_q[11:8];

    fld   = slot_field(idx_q);
    nib   = '0;
    blank = 1'b0;
    unique case (fld)
      FLD_PTS_ONES: nib = po;
      FLD_PTS_TENS: begin nib = pt; blank = (ph == 4'd0) && (pt == 4'd0); end
      FLD_PTS_HUND: begin nib = ph; blank = (ph == 4'd0); end
      FLD_TENTHS:   nib = tt;
      FLD_ONES:     nib = on;
      FLD_TENS:     begin nib = te; blank = (th == 4'd0) && (hu == 4'd0) && (te == 4'd0); end
      FLD_HUND:     begin nib = hu; blank = (th == 4'd0) && (hu == 4'd0); end
      default:      begin nib = th; blank = (th == 4'd0); end
    endcase

    seg_d = ((BLANK_LEADING != 0) && blank) ? SEG_BLANK : seg_decode(nib);
    an_d  = '1;
    an_d[idx_q] = 1'b0;
    dp_d  = (fld != FLD_ONES);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      pts_q    <= '0;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (snap)      shadow_q <= digit[27:8];
      if (conv_done) pts_q    <= conv_bcd;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
